// File: rtl/normalize32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | normalize32 : multi-cycle 32-bit normalizer, 5-step binary search, start/done |
// | Optional: NORM32_SIGNED_EN selects two's-complement (redundant sign) mode     |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module normalize32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_data,
  output logic [4:0]  shift,
  output logic        zero
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_w;
  logic [4:0]  r_acc;
  logic [2:0]  r_k;

  logic [31:0] w_mask;
  logic [31:0] w_shifted;
  logic        w_take;
  logic [31:0] w_w_next;
  logic [4:0]  w_acc_next;

  // The mask covers the bits that must be redundant for step k to shift by 2^k.
  always_comb begin
    w_mask    = 32'h0000_0000;
    w_shifted = r_w;
    case (r_k)
`ifdef NORM32_SIGNED_EN
      3'd4: begin w_mask = 32'hFFFF_8000; w_shifted = {r_w[15:0], 16'h0000}; end
      3'd3: begin w_mask = 32'hFF80_0000; w_shifted = {r_w[23:0], 8'h00};    end
      3'd2: begin w_mask = 32'hF800_0000; w_shifted = {r_w[27:0], 4'h0};     end
      3'd1: begin w_mask = 32'hE000_0000; w_shifted = {r_w[29:0], 2'b00};    end
      3'd0: begin w_mask = 32'hC000_0000; w_shifted = {r_w[30:0], 1'b0};     end
`else
      3'd4: begin w_mask = 32'hFFFF_0000; w_shifted = {r_w[15:0], 16'h0000}; end
      3'd3: begin w_mask = 32'hFF00_0000; w_shifted = {r_w[23:0], 8'h00};    end
      3'd2: begin w_mask = 32'hF000_0000; w_shifted = {r_w[27:0], 4'h0};     end
      3'd1: begin w_mask = 32'hC000_0000; w_shifted = {r_w[29:0], 2'b00};    end
      3'd0: begin w_mask = 32'h8000_0000; w_shifted = {r_w[30:0], 1'b0};     end
`endif
      default: begin w_mask = 32'h0000_0000; w_shifted = r_w; end
    endcase
  end

`ifdef NORM32_SIGNED_EN
  assign w_take = ((r_w & w_mask) == 32'h0000_0000) || ((r_w & w_mask) == w_mask);
`else
  assign w_take = ((r_w & w_mask) == 32'h0000_0000);
`endif

  assign w_w_next   = w_take ? w_shifted : r_w;
  assign w_acc_next = w_take ? (r_acc | (5'd1 << r_k)) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_w      <= 32'h0000_0000;
      r_acc    <= 5'd0;
      r_k      <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_data <= 32'h0000_0000;
      shift    <= 5'd0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w     <= in_data;
            r_acc   <= 5'd0;
            r_k     <= 3'd4;
            busy    <= 1'b1;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          r_w   <= w_w_next;
          r_acc <= w_acc_next;
          if (r_k == 3'd0) begin
            // Only a zero operand can end the search as an all-zero word.
            out_data <= w_w_next;
            shift    <= w_acc_next;
            zero     <= (w_w_next == 32'h0000_0000);
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_k <= r_k - 3'd1;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_normalize32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_normalize32 : scoreboard bench for normalize32 (both NORM32_SIGNED_EN modes) |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_normalize32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic [4:0]  shift;
  logic        zero;

  normalize32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .out_data (out_data),
    .shift    (shift),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  sh;
    logic        z;
    logic [31:0] op;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count bits below the MSB region that are redundant, capped at 31.
  function automatic exp_t model(input logic [31:0] op);
    exp_t e;
    int   s;
    logic run;
    s   = 0;
    run = 1'b1;
`ifdef NORM32_SIGNED_EN
    for (int i = 30; i >= 0; i--) begin
      if (run && (op[i] == op[31])) s++; else run = 1'b0;
    end
`else
    for (int i = 31; i >= 1; i--) begin
      if (run && !op[i]) s++; else run = 1'b0;
    end
`endif
    e.out = op << s;
    e.sh  = 5'(s);
    e.z   = (op == 32'h0);
    e.op  = op;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with shift=%0d expected no pending result", shift);
      end else begin
        e = q.pop_front();
        check("out_data", out_data, e.out);
        check("shift", 32'(shift), 32'(e.sh));
        check("zero", 32'(zero), 32'(e.z));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
`ifdef NORM32_SIGNED_EN
        if (e.op != 32'h0 && e.op != 32'hFFFF_FFFF)
          check("msb_invariant", 32'(out_data[31] ^ out_data[30]), 32'd1);
`else
        if (e.op != 32'h0)
          check("msb_invariant", 32'(out_data[31]), 32'd1);
`endif
      end
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b expected 0", busy);
    end
  endtask

  task automatic issue(input logic [31:0] op, input logic [31:0] eo,
                       input logic [4:0] es, input logic ez);
    exp_t e;
    wait_idle();
    in_data = op;
    start   = 1'b1;
    @(posedge clk);
    #1;
    e.out = eo; e.sh = es; e.z = ez; e.op = op; e.cyc = cyc + 5;
    q.push_back(e);
    start   = 1'b0;
    in_data = $urandom;
  endtask

`ifdef NORM32_SIGNED_EN
  localparam logic [31:0] c_B2B_OUT = 32'h6000_0000;
  localparam logic [4:0]  c_B2B_SH  = 5'd21;
  localparam logic [31:0] c_RST_OUT = 32'h4000_0000;
  localparam logic [4:0]  c_RST_SH  = 5'd0;
`else
  localparam logic [31:0] c_B2B_OUT = 32'hC000_0000;
  localparam logic [4:0]  c_B2B_SH  = 5'd22;
  localparam logic [31:0] c_RST_OUT = 32'h8000_0000;
  localparam logic [4:0]  c_RST_SH  = 5'd1;
`endif

  initial begin : stim
    int   nb;
    int   c0;
    int   guard;
    exp_t e;
    logic [31:0] op;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_shift", 32'(shift), 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;

`ifdef NORM32_SIGNED_EN
    issue(32'h0000_0001, 32'h4000_0000, 5'd30, 1'b0);
    issue(32'h0001_0000, 32'h4000_0000, 5'd14, 1'b0);
    issue(32'hF000_0000, 32'h8000_0000, 5'd3,  1'b0);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 1'b0);
    issue(32'hFFFF_8000, 32'h8000_0000, 5'd16, 1'b0);
`else
    issue(32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0);
    issue(32'h0001_0000, 32'h8000_0000, 5'd15, 1'b0);
    issue(32'hF000_0000, 32'hF000_0000, 5'd0,  1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b0);
    issue(32'hFFFF_8000, 32'hFFFF_8000, 5'd0,  1'b0);
`endif

    // Zero operand: busy spans exactly six cycles.
    issue(32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1);
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    check("busy_cycles", 32'(nb), 32'd6);

    // Back-to-back: start held high, accepts at c0, c0+7, c0+14.
    wait_idle();
    in_data = 32'h0000_0300;
    start   = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      e.out = c_B2B_OUT; e.sh = c_B2B_SH; e.z = 1'b0; e.op = 32'h300; e.cyc = c0 + 5 + 7 * i;
      q.push_back(e);
    end
    repeat (17) @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    // Reset during step k=2 aborts with no done pulse.
    wait_idle();
    in_data = 32'h0000_0010;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out_data", out_data, 32'h0);
    check("abort_shift", 32'(shift), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(32'h4000_0000, c_RST_OUT, c_RST_SH, 1'b0);

    // Random operands with a spread of leading-bit run lengths.
    for (int i = 0; i < 300; i++) begin
      op = $urandom >> $urandom_range(0, 31);
`ifdef NORM32_SIGNED_EN
      if ($urandom_range(0, 1) == 1) op = ~op;
`endif
      e = model(op);
      issue(op, e.out, e.sh, e.z);
    end

    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
